// File: rtl/jtag_dmi_pkg.sv
// Shared DMI/JTAG definitions: op and status codes, IR select value, DR layout, host FSM states.
package jtag_dmi_pkg;
  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_OK     = 2'd0;
  localparam logic [1:0] DMI_FAILED = 2'd2;
  localparam logic [1:0] DMI_BUSY   = 2'd3;

  localparam int         IR_LEN_DEFAULT     = 5;
  localparam logic [4:0] IR_DMI_DEFAULT     = 5'h11;
  localparam int         DMI_ADDR_W_DEFAULT = 6;

  localparam int DR_OP_LSB   = 0;
  localparam int DR_DATA_LSB = 2;
  localparam int DR_ADDR_LSB = 34;
  localparam int DR_LEN      = DMI_ADDR_W_DEFAULT + DR_ADDR_LSB;

  // Scan engine sequence geometry: header TMS bits and trailer TMS bits.
  localparam int HDR_W = 16;
  localparam int TRL_W = 2;

  typedef enum logic [2:0] {
    TAP_RST, IDLE, IR_SCAN, ACC_SCAN, RTI_WAIT, RES_SCAN, RESP
  } state_t;
endpackage

// File: rtl/jtag_scan_engine.sv
// Plays one header/payload/trailer TMS+TDI sequence at TCK = clk/(2*TCK_DIV); pulses done after the last TCK.
// TMS/TDI change with TCK falling, TDO is sampled with TCK rising; the first CAP_W payload bits are captured.
module jtag_scan_engine import jtag_dmi_pkg::*; #(
  parameter int TCK_DIV = 2,
  parameter int PAY_W   = DR_LEN,
  parameter int CAP_W   = DR_DATA_LSB + 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [HDR_W-1:0] hdr_tms,
  input  logic [4:0]       hdr_len,
  input  logic [PAY_W-1:0] pay,
  input  logic [6:0]       pay_len,
  input  logic [TRL_W-1:0] trl_tms,
  input  logic [1:0]       trl_len,
  input  logic             tdo,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  output logic             done,
  output logic [CAP_W-1:0] cap
);
  localparam int SEQ_W = HDR_W + PAY_W + TRL_W;
  localparam int IW    = $clog2(SEQ_W + 1);
  localparam int DW    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [SEQ_W-1:0] tms_seq, tdi_seq, tms_sr, tdi_sr;
  logic [IW-1:0]    pay_end, cap_end, total;
  logic [IW-1:0]    idx, last_idx, pay_lo, cap_hi;
  logic [DW-1:0]    div_cnt;
  logic             active;

  // Flatten the three segments into one bit-serial TMS/TDI stream; the last payload bit exits Shift.
  always_comb begin
    pay_end = IW'(hdr_len) + IW'(pay_len);
    cap_end = (pay_len > 7'(CAP_W)) ? IW'(hdr_len) + IW'(CAP_W) : pay_end;
    total   = pay_end + IW'(trl_len);
    tms_seq = (SEQ_W'(hdr_tms) & ((SEQ_W'(1) << hdr_len) - SEQ_W'(1)))
            | ((SEQ_W'(trl_tms) & ((SEQ_W'(1) << trl_len) - SEQ_W'(1))) << pay_end);
    if (pay_len != 7'd0) tms_seq = tms_seq | (SEQ_W'(1) << (pay_end - IW'(1)));
    tdi_seq = SEQ_W'(pay) << hdr_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b1;
      done     <= 1'b0;
      active   <= 1'b0;
      cap      <= '0;
      tms_sr   <= '0;
      tdi_sr   <= '0;
      idx      <= '0;
      last_idx <= '0;
      pay_lo   <= '0;
      cap_hi   <= '0;
      div_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start && total == '0) begin
          done <= 1'b1;
        end else if (start) begin
          active   <= 1'b1;
          tms_sr   <= tms_seq;
          tdi_sr   <= tdi_seq;
          tms      <= tms_seq[0];
          tdi      <= tdi_seq[0];
          idx      <= '0;
          last_idx <= total - IW'(1);
          pay_lo   <= IW'(hdr_len);
          cap_hi   <= cap_end;
          div_cnt  <= '0;
        end
      end else if (div_cnt == DW'(TCK_DIV - 1)) begin
        div_cnt <= '0;
        if (!tck) begin
          tck <= 1'b1;
          if (idx >= pay_lo && idx < cap_hi) cap <= {tdo, cap[CAP_W-1:1]};
        end else begin
          tck <= 1'b0;
          if (idx == last_idx) begin
            active <= 1'b0;
            done   <= 1'b1;
            tms    <= 1'b0;
          end else begin
            idx    <= idx + IW'(1);
            tms_sr <= tms_sr >> 1;
            tdi_sr <= tdi_sr >> 1;
            tms    <= tms_sr[1];
            tdi    <= tdi_sr[1];
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end
endmodule

// File: rtl/jtag_dmi_host.sv
// DMI request -> JTAG host: TAP reset, cached IR select, access scan, idle wait, result scan; one request in flight.
// Cached read/write costs 45+IDLE_TCKS+45 TCKs (+11 for the first IR scan); response is held until resp_ready.
module jtag_dmi_host import jtag_dmi_pkg::*; #(
  parameter int              TCK_DIV    = 2,
  parameter int              IR_LEN     = IR_LEN_DEFAULT,
  parameter logic [IR_LEN-1:0] IR_DMI   = IR_DMI_DEFAULT,
  parameter int              DMI_ADDR_W = DMI_ADDR_W_DEFAULT,
  parameter int              RESET_TCKS = 8,
  parameter int              IDLE_TCKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DMI_ADDR_W-1:0] req_addr,
  input  logic [31:0]           req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [1:0]            resp_status,
  output logic                  jtag_TCK,
  output logic                  jtag_TMS,
  output logic                  jtag_TDI,
  input  logic                  jtag_TDO,
  output logic                  busy
);
  localparam int DR_W  = DMI_ADDR_W + DR_ADDR_LSB;
  localparam int CAP_W = DR_DATA_LSB + 32;

  state_t                state;
  logic                  launched, start, ir_loaded, eng_done;
  logic [1:0]            op;
  logic [DMI_ADDR_W-1:0] addr;
  logic [31:0]           data;
  logic [CAP_W-1:0]      cap;
  logic [HDR_W-1:0]      hdr_tms;
  logic [4:0]            hdr_len;
  logic [DR_W-1:0]       pay;
  logic [6:0]            pay_len;
  logic [TRL_W-1:0]      trl_tms;
  logic [1:0]            trl_len;

  // TMS patterns are LSB-first and all start/end in Run-Test/Idle.
  always_comb begin
    hdr_tms = '0;
    hdr_len = '0;
    pay     = '0;
    pay_len = '0;
    trl_tms = '0;
    trl_len = '0;
    case (state)
      TAP_RST: begin
        hdr_tms = HDR_W'((1 << RESET_TCKS) - 1);
        hdr_len = 5'(RESET_TCKS + 1);
      end
      IR_SCAN: begin
        hdr_tms = HDR_W'(4'b0011);
        hdr_len = 5'd4;
        pay     = DR_W'(IR_DMI);
        pay_len = 7'(IR_LEN);
        trl_tms = 2'b01;
        trl_len = 2'd2;
      end
      ACC_SCAN, RES_SCAN: begin
        hdr_tms = HDR_W'(3'b001);
        hdr_len = 5'd3;
        pay     = (state == ACC_SCAN) ? {addr, data, op} : {addr, 32'h0, DMI_OP_NOP};
        pay_len = 7'(DR_W);
        trl_tms = 2'b01;
        trl_len = 2'd2;
      end
      RTI_WAIT: hdr_len = 5'(IDLE_TCKS);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= TAP_RST;
      launched    <= 1'b0;
      start       <= 1'b0;
      ir_loaded   <= 1'b0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_status <= '0;
      busy        <= 1'b1;
      op          <= '0;
      addr        <= '0;
      data        <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          op        <= req_op;
          addr      <= req_addr;
          data      <= req_data;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= !ir_loaded ? IR_SCAN : (req_op == DMI_OP_NOP) ? RES_SCAN : ACC_SCAN;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          if (!launched) begin
            start    <= 1'b1;
            launched <= 1'b1;
          end else if (eng_done) begin
            launched <= 1'b0;
            case (state)
              TAP_RST: begin
                req_ready <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end
              IR_SCAN: begin
                ir_loaded <= 1'b1;
                state     <= (op == DMI_OP_NOP) ? RES_SCAN : ACC_SCAN;
              end
              ACC_SCAN: state <= RTI_WAIT;
              RTI_WAIT: state <= RES_SCAN;
              default: begin
                resp_valid  <= 1'b1;
                resp_data   <= cap[DR_DATA_LSB +: 32];
                resp_status <= cap[DR_OP_LSB +: 2];
                state       <= RESP;
              end
            endcase
          end
        end
      endcase
    end
  end

  jtag_scan_engine #(
    .TCK_DIV (TCK_DIV),
    .PAY_W   (DR_W),
    .CAP_W   (CAP_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hdr_tms (hdr_tms),
    .hdr_len (hdr_len),
    .pay     (pay),
    .pay_len (pay_len),
    .trl_tms (trl_tms),
    .trl_len (trl_len),
    .tdo     (jtag_TDO),
    .tck     (jtag_TCK),
    .tms     (jtag_TMS),
    .tdi     (jtag_TDI),
    .done    (eng_done),
    .cap     (cap)
  );
endmodule

// File: tb/tb_jtag_dmi_host.sv
// Bench for jtag_dmi_host: behavioural TAP + DMI model on the pins, scoreboard of expected responses.
module tb_jtag_dmi_host;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [5:0]  req_addr = 6'd0;
  logic [31:0] req_data = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;
  logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;
  logic        busy;

  always #5 clk = ~clk;

  jtag_dmi_host dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_status(resp_status),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- TAP + DMI model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
    T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic t);
    case (s)
      T_TLR:    return t ? T_TLR    : T_RTI;
      T_RTI:    return t ? T_SEL_DR : T_RTI;
      T_SEL_DR: return t ? T_SEL_IR : T_CAP_DR;
      T_CAP_DR: return t ? T_EX1_DR : T_SH_DR;
      T_SH_DR:  return t ? T_EX1_DR : T_SH_DR;
      T_EX1_DR: return t ? T_UPD_DR : T_PA_DR;
      T_PA_DR:  return t ? T_EX2_DR : T_PA_DR;
      T_EX2_DR: return t ? T_UPD_DR : T_SH_DR;
      T_UPD_DR: return t ? T_SEL_DR : T_RTI;
      T_SEL_IR: return t ? T_TLR    : T_CAP_IR;
      T_CAP_IR: return t ? T_EX1_IR : T_SH_IR;
      T_SH_IR:  return t ? T_EX1_IR : T_SH_IR;
      T_EX1_IR: return t ? T_UPD_IR : T_PA_IR;
      T_PA_IR:  return t ? T_EX2_IR : T_PA_IR;
      T_EX2_IR: return t ? T_UPD_IR : T_SH_IR;
      default:  return t ? T_SEL_DR : T_RTI;
    endcase
  endfunction

  tap_t        ts = T_TLR;
  logic [4:0]  ir = 5'h01, ir_sr = 5'h0, ir_last = 5'h0;
  logic [39:0] dr_sr = '0, dr_last = '0;
  logic [5:0]  dmi_addr = '0;
  logic [31:0] pend_data = '0;
  logic [31:0] model_rdata = '0;
  logic [1:0]  model_status = 2'd0;
  logic [15:0] tms_hist = '0;
  int          ir_upd_cnt = 0, rise_cnt = 0, cyc = 0, last_rise = 0, prev_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign jtag_TDO = (ts == T_SH_DR) ? dr_sr[0] : (ts == T_SH_IR) ? ir_sr[0] : 1'b0;

  always @(posedge jtag_TCK) begin
    rise_cnt  <= rise_cnt + 1;
    tms_hist  <= {tms_hist[14:0], jtag_TMS};
    prev_rise <= last_rise;
    last_rise <= cyc;
    case (ts)
      T_TLR:    ir <= 5'h01;
      T_CAP_IR: ir_sr <= 5'b00001;
      T_SH_IR:  ir_sr <= {jtag_TDI, ir_sr[4:1]};
      T_UPD_IR: begin
        ir         <= ir_sr;
        ir_last    <= ir_sr;
        ir_upd_cnt <= ir_upd_cnt + 1;
      end
      T_CAP_DR: if (ir == 5'h11) dr_sr <= {dmi_addr, pend_data, model_status};
      T_SH_DR:  dr_sr <= {jtag_TDI, dr_sr[39:1]};
      T_UPD_DR: if (ir == 5'h11) begin
        dmi_addr <= dr_sr[39:34];
        if (dr_sr[1:0] != 2'd0) dr_last <= dr_sr;
        if (dr_sr[1:0] == 2'd1) pend_data <= model_rdata;
      end
      default: ;
    endcase
    ts <= tap_next(ts, jtag_TMS);
  end

  // ---------------- scoreboard + stimulus ----------------
  logic [33:0] sb[$];
  int          rise_base = 0;
  bit          rdy_seen = 0;

  task automatic send(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data,
                      input bit expect_resp, input logic [33:0] exp);
    bit ok = 0;
    req_op = op; req_addr = addr; req_data = data; req_valid = 1'b1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (req_ready) ok = 1; else @(negedge clk);
    end
    check("req_accept", ok, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rise_base = rise_cnt;
    rdy_seen  = 0;
    if (ok && expect_resp) sb.push_back(exp);
  endtask

  task automatic get_resp(input string tag, input int exp_rises, input bit hold);
    bit ok = 0;
    logic [33:0] exp;
    resp_ready = !hold;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) rdy_seen = 1;
      if (resp_valid) ok = 1;
    end
    check({tag, "_resp_valid"}, ok, 1);
    exp = (sb.size() > 0) ? sb.pop_front() : 34'h3_ffff_ffff;
    check({tag, "_data"}, resp_data, exp[31:0]);
    check({tag, "_status"}, resp_status, exp[33:32]);
    check({tag, "_tcks"}, rise_cnt - rise_base, exp_rises);
    check({tag, "_req_ready_low"}, rdy_seen, 0);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, resp_valid, 1);
        check({tag, "_hold_data"}, resp_data, exp[31:0]);
        check({tag, "_hold_tck"}, jtag_TCK, 0);
        check({tag, "_hold_tms"}, jtag_TMS, 0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic wait_tap_reset(input string tag);
    bit ok = 0;
    rise_base = rise_cnt;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    check({tag, "_ready"}, ok, 1);
    check({tag, "_tcks"}, rise_cnt - rise_base, 9);
    check({tag, "_tms_seq"}, tms_hist[8:0], 9'b1_1111_1110);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tck"}, jtag_TCK, 0);
    check({tag, "_tms"}, jtag_TMS, 1);
    check({tag, "_tdi"}, jtag_TDI, 1);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_status"}, resp_status, 0);
    check({tag, "_busy"}, busy, 1);
  endtask

  int ir_before;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    wait_tap_reset("tap_rst");
    check("tck_period", last_rise - prev_rise, 4);

    // First write: IR scan plus full access
    ir_before = ir_upd_cnt;
    send(2'd2, 6'h10, 32'h1, 1, {2'b00, 32'h0});
    get_resp("wr", 105, 0);
    check("wr_ir_scans", ir_upd_cnt - ir_before, 1);
    check("wr_ir_value", ir_last, 5'h11);
    check("wr_acc_stream", dr_last, 40'h40_0000_0006);

    // dmstatus read with IR cached
    model_rdata = 32'h0040_0c82;
    ir_before = ir_upd_cnt;
    send(2'd1, 6'h11, 32'h0, 1, {2'b00, 32'h0040_0c82});
    get_resp("rd", 94, 0);
    check("rd_no_ir", ir_upd_cnt - ir_before, 0);
    check("rd_acc_stream", dr_last, {6'h11, 32'h0, 2'b01});

    // Busy status reported, response held while resp_ready is low
    model_status = 2'd3;
    model_rdata  = 32'h1234_5678;
    send(2'd1, 6'h11, 32'h0, 1, {2'b11, 32'h1234_5678});
    get_resp("busy", 94, 1);
    model_status = 2'd0;

    // Reset in the middle of the access scan payload
    send(2'd2, 6'h10, 32'hdead_beef, 0, '0);
    for (int i = 0; i < 4000 && (rise_cnt - rise_base) < 23; i++) @(negedge clk);
    check("mid_reached", rise_cnt - rise_base, 23);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    wait_tap_reset("re_rst");
    model_rdata = 32'hcafe_0123;
    ir_before = ir_upd_cnt;
    send(2'd1, 6'h05, 32'h0, 1, {2'b00, 32'hcafe_0123});
    get_resp("rd2", 105, 0);
    check("rd2_ir_scans", ir_upd_cnt - ir_before, 1);
    check("rd2_acc_stream", dr_last, {6'h05, 32'h0, 2'b01});

    // Back-to-back nops: result scan only
    send(2'd0, 6'h05, 32'h0, 1, {2'b00, 32'hcafe_0123});
    get_resp("nop1", 45, 0);
    send(2'd0, 6'h05, 32'h0, 1, {2'b00, 32'hcafe_0123});
    get_resp("nop2", 45, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jtag_dmi_host.md
Name: jtag_dmi_host

Overview:
- Hardware JTAG debug host: turns a simple valid/ready DMI request (op, addr, data) into TCK/TMS/TDI sequences for the SoC's JTAG TAP, and returns the captured DMI response.
- Replaces the bit-banged testbench host so on-chip test logic and benches can perform DMI reads and writes, such as dmcontrol writes and dmstatus reads.
- Sits between a requester (bench, UART debug bridge) and the jtag_TCK/TMS/TDI/TDO pins of tinyriscv_soc_top.

Parameters:
- TCK_DIV, 2: TCK half-period in clk cycles (>=1).
- IR_LEN, 5: TAP instruction register length.
- IR_DMI, 5'h11: IR value selecting the DMI data register.
- DMI_ADDR_W, 6: DMI address width. DR length = DMI_ADDR_W+34 = 40.
- RESET_TCKS, 8: TMS=1 cycles used for TAP reset.
- IDLE_TCKS, 4: Run-Test/Idle TCK cycles between the access scan and the result scan.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_op  in  2  0 nop, 1 read, 2 write.
- req_addr  in  DMI_ADDR_W  DMI address.
- req_data  in  32  write data.
- resp_valid  out  1  response valid, held until resp_ready.
- resp_ready  in  1  response consumed.
- resp_data  out  32  captured DR[33:2].
- resp_status  out  2  captured DR[1:0] (0 ok, 2 failed, 3 busy).
- jtag_TCK  out  1  generated test clock.
- jtag_TMS  out  1  TMS.
- jtag_TDI  out  1  TDI.
- jtag_TDO  in  1  TDO from the TAP.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - jtag_TCK=0, jtag_TMS=1, jtag_TDI=1.
  - req_ready=0, resp_valid=0, resp_data=0, resp_status=0, busy=1.
  - ir_loaded flag=0.
- TCK generation:
  - TCK toggles every TCK_DIV clk only while the scan engine is active; it idles at 0.
  - TMS and TDI change on the clk where TCK falls.
  - TDO is sampled on the clk where TCK rises, using the pre-edge value.
- State machine states: TAP_RST, IDLE, IR_SCAN, ACC_SCAN, RTI_WAIT, RES_SCAN, RESP.
- TAP_RST (entered after rst deassertion):
  - RESET_TCKS TCKs with TMS=1, then 1 TCK with TMS=0 to reach Run-Test/Idle.
  - Then go to IDLE.
- IDLE:
  - req_ready=1.
  - On handshake, latch op/addr/data and drop req_ready the next clk.
  - If ir_loaded=0, go to IR_SCAN; otherwise go to ACC_SCAN.
- IR_SCAN:
  - TMS sequence 1,1,0,0.
  - Then IR_LEN bits of IR_DMI, LSB first, with TMS=1 on the last bit.
  - Then TMS 1 (Update-IR), 0 (Idle). Total 11 TCKs.
  - Set ir_loaded=1.
- ACC_SCAN:
  - TMS 1,0,0.
  - Then 40 bits of {addr,data,op}, LSB first, with TMS=1 on the last bit.
  - Then TMS 1,0. Total 45 TCKs. Captured bits are discarded.
- RTI_WAIT: IDLE_TCKS TCKs with TMS=0.
- RES_SCAN:
  - Same 45-TCK sequence, shifting {addr,32'h0,2'b00} (nop).
  - TDO bits shift into a 40-bit capture register MSB-first (cap = {tdo,cap[39:1]}).
- RESP:
  - resp_valid=1, resp_data=cap[33:2], resp_status=cap[1:0].
  - Outputs are held stable until resp_ready.
  - On handshake, go to IDLE.
- Op-specific rules:
  - op=0 requests perform only RES_SCAN; ACC_SCAN is skipped.
  - Status 3 (busy) is reported, not retried.
- Latency with IR cached, counted in TCK periods (2*TCK_DIV clk each):
  - Read/write: 45+IDLE_TCKS+45.
  - First request after reset: 11 additional TCKs.
- rst mid-operation:
  - All outputs return to reset values immediately.
  - ir_loaded is cleared and TAP_RST is re-run.
  - A partial scan is abandoned, since TMS=1 resets the TAP from any state.
- resp_ready held low keeps the FSM in RESP; jtag pins stay idle (TCK=0, TMS=0).
- req_valid while busy is ignored; there is no queueing.

Decomposition:
- Shared package jtag_dmi_pkg holds:
  - op encodings (DMI_OP_NOP/READ/WRITE);
  - status encodings (DMI_OK/FAILED/BUSY);
  - IR_DMI;
  - DR length and field offsets;
  - FSM state encoding.
- One sub-module, jtag_scan_engine, covering TCK divider, bit counter and shift/capture registers.
  - Inputs: start, header TMS pattern/length, payload bits/length, trailer pattern.
  - Outputs: done pulse and capture word.

Test Plan:
- Reset then idle, TCK_DIV=2: exactly 8 TCK rises with TMS=1 followed by 1 with TMS=0; req_ready=1 afterwards; TCK period = 4 clk.
- Write addr 6'h10, data 32'h1, op 2: one IR scan shifts 5'h11; ACC_SCAN TDI stream LSB-first equals 40'h40_0000_0006; resp_status=0.
- Read addr 6'h11 with TAP/DM model dmstatus=32'h0040_0c82: the second request has no IR scan; resp_data=32'h0040_0c82, resp_status=0.
- DM model returns op=2'b11 on the result scan: resp_status=3; resp_valid held 10 clk with resp_ready=0; data stable throughout; TCK idle.
- Assert rst mid-way through ACC_SCAN at bit 20: outputs return to reset values at once; after release the next request performs TAP_RST, IR scan, then a correct access.
- Back-to-back nop requests: each has 45 TCKs only; req_ready low throughout; resp_data reflects the model's last read.
